// File: rtl/piano_pwm_out.sv
// PWM audio output stage: FIFO-buffered 8-bit samples, each replayed for SAMPLE_REPEAT
// 256-cycle PWM periods. Optional volume attenuation is enabled by defining PIANO_PWM_VOLUME_EN.
module piano_pwm_out #(
  parameter int FIFO_DEPTH    = 4,
  parameter int PREFILL       = 2,
  parameter int SAMPLE_REPEAT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [7:0]                        wave_in,
  input  logic                              wave_valid,
`ifdef PIANO_PWM_VOLUME_EN
  input  logic [2:0]                        vol,
`endif
  output logic                              wave_ready,
  output logic                              pwm_out,
  output logic                              playing,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int REP_W  = (SAMPLE_REPEAT > 1) ? $clog2(SAMPLE_REPEAT) : 1;
  localparam logic [FILL_W-1:0] FULL_LVL    = FILL_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] PREFILL_LVL = FILL_W'(PREFILL);
  localparam logic [REP_W-1:0]  REP_LAST    = REP_W'(SAMPLE_REPEAT - 1);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, next_state;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic [7:0]        cnt, cur_sample, cmp_sample;
  logic [REP_W-1:0]  rep;
  logic              push, pop, start, boundary, starve, active;

  assign wave_ready = (fill != FULL_LVL);
  assign push       = wave_valid && wave_ready;
  assign playing    = (state == PLAY);
  assign active     = (state == PLAY) && en;

  always_comb begin
    next_state = state;
    start      = 1'b0;
    boundary   = 1'b0;
    case (state)
      IDLE: begin
        if (en && fill >= PREFILL_LVL) begin
          next_state = PLAY;
          start      = 1'b1;
        end
      end
      PLAY: begin
        // Dropping en wins over a coincident sample boundary: nothing is popped or flagged.
        if (!en) next_state = IDLE;
        else     boundary   = (cnt == 8'hFF) && (rep == REP_LAST);
      end
      default: next_state = IDLE;
    endcase
  end

  // Pop decisions use the registered level, so a same-edge push never rescues an underrun.
  assign pop    = start || (boundary && fill != '0);
  assign starve = boundary && (fill == '0);

`ifdef PIANO_PWM_VOLUME_EN
  logic signed [8:0] diff, scaled;
  assign diff       = $signed({1'b0, cur_sample}) - 9'sd128;
  assign scaled     = diff >>> vol;
  assign cmp_sample = 8'h80 + scaled[7:0];
`else
  assign cmp_sample = cur_sample;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      fill <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wave_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rep        <= '0;
      cur_sample <= 8'h80;
      pwm_out    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= starve;
      pwm_out  <= active && (cnt < cmp_sample);
      if (pop)         cur_sample <= mem[head];
      else if (starve) cur_sample <= 8'h80;
      if (active) begin
        cnt <= cnt + 1'b1;
        if (cnt == 8'hFF) rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
      end else begin
        cnt <= '0;
        rep <= '0;
      end
    end
  end

endmodule

// File: tb/tb_piano_pwm_out.sv
// Scoreboard bench for piano_pwm_out: a queue-based playback model predicts every cycle's
// outputs; a separate monitor compares them one cycle after each stimulus edge.
`timescale 1ns/1ps
module tb_piano_pwm_out;

  localparam int FIFO_DEPTH    = 4;
  localparam int PREFILL       = 2;
  localparam int SAMPLE_REPEAT = 4;
  localparam int SLOT          = 256 * SAMPLE_REPEAT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wave_valid = 1'b0;
  logic [7:0] wave_in = 8'h00;
  logic       wave_ready, pwm_out, playing, underrun;
  logic [2:0] fill;
`ifdef PIANO_PWM_VOLUME_EN
  logic [2:0] vol = 3'd0;
`endif

  piano_pwm_out #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PREFILL(PREFILL),
    .SAMPLE_REPEAT(SAMPLE_REPEAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .wave_in(wave_in),
    .wave_valid(wave_valid),
`ifdef PIANO_PWM_VOLUME_EN
    .vol(vol),
`endif
    .wave_ready(wave_ready),
    .pwm_out(pwm_out),
    .playing(playing),
    .underrun(underrun),
    .fill(fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pwm;
    bit play;
    bit under;
    int lvl;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a sample queue plus a count of cycles spent playing.
  logic [7:0] m_q[$];
  bit         m_play = 0;
  int         m_t = 0;
  int         m_cur = 128;
  bit         m_pwm = 0;
  bit         m_under = 0;
  bit         last_accepted = 0;

  function automatic int eff_sample(int c, int v);
    int d;
    d = c - 128;
    d = d >>> v;
    return (128 + d) & 255;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input logic [7:0] d);
    exp_t x;
    bit   acc;
    int   vv;
    @(negedge clk);
    rst_n      = r;
    en         = e;
    wave_valid = v;
    wave_in    = d;
    vv         = 0;
`ifdef PIANO_PWM_VOLUME_EN
    if ($urandom_range(0, 299) == 0) vol = 3'($urandom_range(0, 7));
    vv = int'(vol);
`endif
    acc = 0;
    if (!r) begin
      m_q.delete();
      m_play  = 0;
      m_t     = 0;
      m_cur   = 128;
      m_pwm   = 0;
      m_under = 0;
    end else begin
      acc     = v && (m_q.size() < FIFO_DEPTH);
      m_under = 0;
      if (!m_play) begin
        m_pwm = 0;
        if (e && m_q.size() >= PREFILL) begin
          m_cur  = int'(m_q.pop_front());
          m_play = 1;
          m_t    = 0;
        end
      end else if (!e) begin
        m_play = 0;
        m_pwm  = 0;
        m_t    = 0;
      end else begin
        m_pwm = ((m_t % 256) < eff_sample(m_cur, vv));
        if (m_t % SLOT == SLOT - 1) begin
          if (m_q.size() > 0) m_cur = int'(m_q.pop_front());
          else begin
            m_cur   = 128;
            m_under = 1;
          end
        end
        m_t++;
      end
      if (acc) m_q.push_back(d);
    end
    last_accepted = acc;
    x.pwm   = m_pwm;
    x.play  = m_play;
    x.under = m_under;
    x.lvl   = m_q.size();
    x.ready = (m_q.size() < FIFO_DEPTH);
    exp_q.push_back(x);
  endtask

  // Monitor: compares the DUT against the oldest prediction just after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("pwm_out", int'(pwm_out), int'(x.pwm));
        checkOutput("playing", int'(playing), int'(x.play));
        checkOutput("underrun", int'(underrun), int'(x.under));
        checkOutput("fill", int'(fill), x.lvl);
        checkOutput("wave_ready", int'(wave_ready), int'(x.ready));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] bp_vals[5];
    logic [7:0] dat;
    bit         pend;
    bit         e_r;
    int         guard;

    // Reset held with random inputs, then idle with en high but nothing pushed.
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'($urandom), 1'($urandom), 8'($urandom));
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 8'($urandom));

    // Two 0x40 samples then starvation: repeated underruns fill in silence.
    applyStimulus(1, 1, 1, 8'h40);
    applyStimulus(1, 1, 1, 8'h40);
    for (int i = 0; i < 3300; i++) applyStimulus(1, 1, 0, 8'($urandom));

    // Duty extremes.
    applyStimulus(1, 1, 1, 8'h00);
    applyStimulus(1, 1, 1, 8'hFF);
    applyStimulus(1, 1, 1, 8'h80);
    for (int i = 0; i < 4200; i++) applyStimulus(1, 1, 0, 8'($urandom));

    // Back-pressure with playback disabled; the fifth sample waits for the first pop.
    bp_vals[0] = 8'h10; bp_vals[1] = 8'h20; bp_vals[2] = 8'h30;
    bp_vals[3] = 8'h40; bp_vals[4] = 8'hC0;
    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, bp_vals[i]);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, bp_vals[4]);
    guard = 0;
    do begin
      applyStimulus(1, 1, 1, bp_vals[4]);
      guard++;
    end while (!last_accepted && guard < 10);

    // Random traffic with occasional single-cycle enable drops.
    pend = 0;
    dat  = 8'h00;
    for (int i = 0; i < 8000; i++) begin
      if (!pend && $urandom_range(0, 699) == 0) begin
        pend = 1;
        dat  = 8'($urandom);
      end
      e_r = ($urandom_range(0, 1499) != 0);
      applyStimulus(1, e_r, pend, dat);
      if (last_accepted) pend = 0;
    end

    // Reset part-way through a sample with a well-filled FIFO, then re-prime from scratch.
    guard = 0;
    while (!(m_play && m_q.size() >= 3) && guard < 5000) begin
      applyStimulus(1, 1, 1, 8'($urandom));
      guard++;
    end
    for (int i = 0; i < int'($urandom_range(90, 110)); i++) applyStimulus(1, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 8'($urandom));
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 8'h00);
    applyStimulus(1, 1, 1, 8'h60);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 8'h00);
    applyStimulus(1, 1, 1, 8'hA0);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 8'h00);

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piano_pwm_out.md
Name: piano_pwm_out

Overview:
Audio output stage that consumes the 8-bit `wave` samples produced by the piano synthesizer and drives a 1-bit PWM pin for an RC-filtered speaker.
- Samples enter through a valid/ready handshake into a small FIFO.
- Each sample is replayed for a fixed number of PWM periods.
- An empty FIFO at a sample boundary (underrun) is flagged and filled with midscale silence.

Parameters:
- FIFO_DEPTH, 4: sample FIFO entries; power of two, minimum 2.
- PREFILL, 2: FIFO level required to leave IDLE; range 1..FIFO_DEPTH.
- SAMPLE_REPEAT, 4: PWM periods (256 clk each) per sample; minimum 1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: playback enable.
- wave_in, in, 8: unsigned sample; 8'h80 is silence.
- wave_valid, in, 1: wave_in valid.
- wave_ready, out, 1: FIFO can accept; equals !full.
- pwm_out, out, 1: registered PWM output.
- playing, out, 1: high while in PLAY.
- underrun, out, 1: one-cycle pulse on underrun.
- fill, out, $clog2(FIFO_DEPTH+1): current FIFO level.

Behaviour:
- Reset (async assert, sync release) values:
  - pwm_out=0, playing=0, underrun=0, fill=0, wave_ready=1.
  - FIFO emptied; cnt=0, rep=0, cur_sample=8'h80; state IDLE.
- Push: occurs on any edge where wave_valid && wave_ready, independent of state and en.
  - wave_in is written at the tail; fill increments on the next cycle.
  - When full, wave_ready=0 and wave_in is ignored.
- Registers:
  - cnt: 8-bit PWM counter.
  - rep: 0..SAMPLE_REPEAT-1.
  - cur_sample: 8-bit sample currently playing.
- IDLE state:
  - cnt and rep held at 0; pwm_out=0.
  - If en && fill>=PREFILL: on the next edge go to PLAY, pop the head into cur_sample, cnt=0, rep=0.
- PLAY state:
  - cnt increments every cycle and wraps 255->0.
  - On cnt==255, rep increments, wrapping at SAMPLE_REPEAT-1.
  - pwm_out <= (cnt < cur_sample), giving 1 cycle latency.
  - Duty is cur_sample/256: 8'h00 is always low; 8'hFF is high 255 of 256 cycles.
- Sample boundary: the edge where cnt==255 && rep==SAMPLE_REPEAT-1.
  - FIFO non-empty: pop the head into cur_sample.
  - FIFO empty: cur_sample <= 8'h80 and underrun=1 for exactly the next cycle; stay in PLAY.
- No bypass: a push on the same edge as a boundary pop into an empty FIFO still counts as an underrun. The pushed sample plays at the next boundary.
- Simultaneous push and pop: fill is unchanged; head and tail pointers both advance.
- en low in PLAY: next edge goes to IDLE.
  - pwm_out=0 from the cycle after.
  - FIFO contents retained; cur_sample retained until the next pop.
- Reset mid-operation: immediate return to reset values. Any partially played sample and all FIFO contents are discarded.
- playing=1 exactly while state==PLAY (registered with the state).

Optional Feature:
Macro PIANO_PWM_VOLUME_EN.
- Defined:
  - Adds input port vol (3 bits).
  - The sample used for comparison is 8'h80 + ((cur_sample - 8'h80) >>> vol). The subtraction is 9-bit signed, the shift arithmetic, and the result truncated to 8 bits.
  - vol=0 gives unchanged output; vol=7 gives near-silence at 127..128.
  - vol is sampled every cycle; a change takes effect on the next PWM compare.
- Undefined: no vol port; cur_sample is compared directly.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> pwm_out=0, playing=0, underrun=0, fill=0, wave_ready=1. Release -> state unchanged until pushes occur.
2. Play a sample: en=1, push two samples of 8'h40 -> playing rises one cycle after fill reaches 2. pwm_out is high 64 of every 256 cycles for 4 periods per sample, with no underrun for 2048 cycles.
3. Duty extremes: push 8'h00, 8'hFF, 8'h80 -> duty cycles 0/256, 255/256 and 128/256 in successive 1024-cycle slots.
4. Back-pressure: en=0, push 5 samples with wave_valid held -> fill=4, wave_ready=0 after the 4th push, 5th sample not accepted. Set en=1 -> first pop frees a slot and the 5th sample is accepted the next cycle.
5. Underrun: en=1, push exactly 2 samples, then stop -> after 2048 PWM cycles, underrun pulses for 1 cycle and pwm_out duty becomes 128/256. Pulse repeats every 1024 cycles while starved.
6. Mid-play reset: assert rst_n at cnt≈100 of a sample with FIFO fill=3 -> pwm_out and playing fall immediately and fill=0. After release, re-entry to PLAY needs 2 fresh pushes.
